dds_key_ctrl: RTL and testbench

//  Front-panel control stage sitting directly upstream of the DDS controller.

---
 rtl/dds_key_ctrl_pkg.sv | 33 +++
 rtl/dds_key_ctrl_key_filter.sv | 52 +++++
 rtl/dds_key_ctrl.sv | 102 ++++++++++
 tb/tb_dds_key_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dds_key_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dds_key_ctrl_pkg
//  Purpose  : Constants shared between the front-panel key controller and the
//             DDS controller: debounce hold time, frequency step limits and
//             waveform page encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dds_key_ctrl_pkg;

    // Debounce hold time in sys_clk cycles (20 ms at 50 MHz).
    localparam logic [19:0] CNT_MAX_DEF = 20'd999_999;

    // Frequency step limits: up to +31 steps, down to -19 steps of 50 kHz.
    localparam logic [4:0]  UP_MAX      = 5'd31;
    localparam logic [4:0]  DN_MAX      = 5'd19;

    // Waveform ROM page select as seen by the DDS controller.
    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_1    = 2'd1,
        WAVE_2    = 2'd2,
        WAVE_3    = 2'd3
    } wave_e;

    // Next waveform page; the 2-bit add wraps WAVE_3 back to WAVE_SINE.
    function automatic logic [1:0] wave_next(input logic [1:0] wave);
        return wave + 2'd1;
    endfunction

endpackage : dds_key_ctrl_pkg
`default_nettype wire

// File: rtl/dds_key_ctrl_key_filter.sv
`default_nettype none
// ============================================================================
//  Module   : dds_key_ctrl_key_filter
//  Purpose  : Debounces one active-low push-button. Two-flop synchroniser,
//             then a hold counter that must see the key low for CNT_MAX
//             consecutive cycles; emits a single-cycle press flag.
//  Ports    : sys_clk    - system clock
//             sys_rst_n  - asynchronous active-low reset
//             i_key_in_n - raw button, active-low, asynchronous to sys_clk
//             o_key_flag - one-cycle pulse per accepted press
//  Revision : 1.0 - initial release
// ============================================================================
module dds_key_ctrl_key_filter
    import dds_key_ctrl_pkg::*;
#(
    parameter logic [19:0] CNT_MAX = CNT_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_in_n,
    output logic o_key_flag
);

    logic        r_sync1;
    logic        r_sync2;
    logic [19:0] r_cnt;

    // Sync flops reset to 1 (released) so a key held through reset must
    // complete a full hold time again before it is accepted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_in_n;
            r_sync2 <= r_sync1;
            if (r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    // The counter passes CNT_MAX-1 exactly once per press and then parks at
    // CNT_MAX, so a long hold never repeats. Qualifying with the synced level
    // means the key must be seen low for the full CNT_MAX samples.
    assign o_key_flag = !r_sync2 && (r_cnt == (CNT_MAX - 20'd1));

endmodule : dds_key_ctrl_key_filter
`default_nettype wire

// File: rtl/dds_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dds_key_ctrl
//  Purpose  : Front-panel control stage for the DDS. Debounces the wave,
//             freq-up and freq-down buttons and maintains the waveform select
//             and the up/down frequency step counters consumed by the DDS.
//             Output frequency = 1 MHz + 50 kHz * (freq_counter - freq_counter2).
//  Ports    : sys_clk              - 50 MHz system clock
//             sys_rst_n            - asynchronous active-low reset
//             i_key_wave_n         - wave-select button, active-low
//             i_key_up_n           - freq-up button, active-low
//             i_key_dn_n           - freq-down button, active-low
//             o_waveform_counter   - waveform page select (registered)
//             o_freq_counter       - freq-up step count (registered)
//             o_freq_counter2      - freq-down step count (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module dds_key_ctrl
    import dds_key_ctrl_pkg::*;
#(
    parameter logic [19:0] CNT_MAX = CNT_MAX_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       i_key_wave_n,
    input  logic       i_key_up_n,
    input  logic       i_key_dn_n,
    output logic [1:0] o_waveform_counter,
    output logic [4:0] o_freq_counter,
    output logic [4:0] o_freq_counter2
);

    logic       w_wave_flag;
    logic       w_up_flag;
    logic       w_dn_flag;
    logic       w_up_only;
    logic       w_dn_only;

    logic [1:0] r_wave;
    logic [4:0] r_freq_up;
    logic [4:0] r_freq_dn;

    dds_key_ctrl_key_filter #(.CNT_MAX(CNT_MAX)) u_key_wave (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_key_in_n (i_key_wave_n),
        .o_key_flag (w_wave_flag)
    );

    dds_key_ctrl_key_filter #(.CNT_MAX(CNT_MAX)) u_key_up (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_key_in_n (i_key_up_n),
        .o_key_flag (w_up_flag)
    );

    dds_key_ctrl_key_filter #(.CNT_MAX(CNT_MAX)) u_key_dn (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_key_in_n (i_key_dn_n),
        .o_key_flag (w_dn_flag)
    );

    // Up and down landing in the same cycle cancel each other out.
    assign w_up_only = w_up_flag && !w_dn_flag;
    assign w_dn_only = w_dn_flag && !w_up_flag;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wave    <= WAVE_SINE;
            r_freq_up <= '0;
            r_freq_dn <= '0;
        end else begin
            if (w_wave_flag) begin
                r_wave <= wave_next(r_wave);
            end

            // The two step counters form a signed offset; only one of them
            // is ever non-zero, so a step toward zero always unwinds the
            // opposite counter before growing this one.
            if (w_up_only) begin
                if (r_freq_dn != 5'd0) begin
                    r_freq_dn <= r_freq_dn - 5'd1;
                end else if (r_freq_up < UP_MAX) begin
                    r_freq_up <= r_freq_up + 5'd1;
                end
            end else if (w_dn_only) begin
                if (r_freq_up != 5'd0) begin
                    r_freq_up <= r_freq_up - 5'd1;
                end else if (r_freq_dn < DN_MAX) begin
                    r_freq_dn <= r_freq_dn + 5'd1;
                end
            end
        end
    end

    assign o_waveform_counter = r_wave;
    assign o_freq_counter     = r_freq_up;
    assign o_freq_counter2    = r_freq_dn;

endmodule : dds_key_ctrl
`default_nettype wire

// File: tb/tb_dds_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_key_ctrl
//  Purpose  : Self-checking bench for dds_key_ctrl with a 10-cycle debounce.
//             A vector table of button presses with expected outputs, plus
//             hand-written sequences for latency, bounce, saturation and
//             reset during a press.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_key_ctrl;

    localparam logic [19:0] C_CNT_MAX = 20'd10;
    localparam int          C_NVEC    = 15;

    // Button selectors used by the stimulus.
    localparam int K_WAVE    = 0;
    localparam int K_UP      = 1;
    localparam int K_DN      = 2;
    localparam int K_UPDN    = 3;
    localparam int K_WAVE_UP = 4;
    localparam int K_WAVE_DN = 5;

    typedef struct {
        int         which;
        int         hold;
        logic [1:0] exp_w;
        logic [4:0] exp_fc;
        logic [4:0] exp_fc2;
    } vec_t;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_wave_n;
    logic       key_up_n;
    logic       key_dn_n;
    logic [1:0] waveform_counter;
    logic [4:0] freq_counter;
    logic [4:0] freq_counter2;

    int n_vec;
    int n_err;

    vec_t tbl [C_NVEC];

    dds_key_ctrl #(.CNT_MAX(C_CNT_MAX)) dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .i_key_wave_n       (key_wave_n),
        .i_key_up_n         (key_up_n),
        .i_key_dn_n         (key_dn_n),
        .o_waveform_counter (waveform_counter),
        .o_freq_counter     (freq_counter),
        .o_freq_counter2    (freq_counter2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [1:0] ew,
                         input logic [4:0] efc, input logic [4:0] efc2);
        n_vec++;
        if (waveform_counter !== ew || freq_counter !== efc || freq_counter2 !== efc2) begin
            n_err++;
            $display("FAIL %s: got wave=%0d fc=%0d fc2=%0d, expected wave=%0d fc=%0d fc2=%0d",
                     nm, waveform_counter, freq_counter, freq_counter2, ew, efc, efc2);
        end
    endtask

    task automatic set_keys(input int which, input logic v);
        case (which)
            K_WAVE:    key_wave_n = v;
            K_UP:      key_up_n   = v;
            K_DN:      key_dn_n   = v;
            K_UPDN:    begin key_up_n = v;   key_dn_n = v; end
            K_WAVE_UP: begin key_wave_n = v; key_up_n = v; end
            K_WAVE_DN: begin key_wave_n = v; key_dn_n = v; end
            default:   ;
        endcase
    endtask

    // Key low for 'hold' sampled edges, then released and left to settle.
    task automatic press(input int which, input int hold);
        @(negedge sys_clk);
        set_keys(which, 1'b0);
        repeat (hold) @(negedge sys_clk);
        set_keys(which, 1'b1);
        repeat (16) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("reset_asserted", 2'd0, 5'd0, 5'd0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("reset_released", 2'd0, 5'd0, 5'd0);
    endtask

    initial begin
        logic [1:0] wave_exp [5];
        logic [1:0] wprev;
        int         efc;
        int         efc2;

        n_vec      = 0;
        n_err      = 0;
        sys_rst_n  = 1'b0;
        key_wave_n = 1'b1;
        key_up_n   = 1'b1;
        key_dn_n   = 1'b1;

        // which, hold, wave, fc, fc2 (state accumulates from reset)
        tbl[0]  = '{K_UP,      15, 2'd0, 5'd1, 5'd0};
        tbl[1]  = '{K_UP,      15, 2'd0, 5'd2, 5'd0};
        tbl[2]  = '{K_DN,      15, 2'd0, 5'd1, 5'd0};
        tbl[3]  = '{K_DN,      15, 2'd0, 5'd0, 5'd0};
        tbl[4]  = '{K_DN,      15, 2'd0, 5'd0, 5'd1};
        tbl[5]  = '{K_DN,      15, 2'd0, 5'd0, 5'd2};
        tbl[6]  = '{K_DN,      15, 2'd0, 5'd0, 5'd3};
        tbl[7]  = '{K_UP,      15, 2'd0, 5'd0, 5'd2};
        tbl[8]  = '{K_UPDN,    15, 2'd0, 5'd0, 5'd2};
        tbl[9]  = '{K_WAVE_UP, 15, 2'd1, 5'd0, 5'd1};
        tbl[10] = '{K_WAVE_DN, 15, 2'd2, 5'd0, 5'd2};
        tbl[11] = '{K_UP,       8, 2'd2, 5'd0, 5'd2};
        tbl[12] = '{K_WAVE,     9, 2'd2, 5'd0, 5'd2};
        tbl[13] = '{K_WAVE,    10, 2'd3, 5'd0, 5'd2};
        tbl[14] = '{K_WAVE,    10, 2'd0, 5'd0, 5'd2};

        // Reset with keys idle.
        repeat (3) @(negedge sys_clk);
        check("reset_initial", 2'd0, 5'd0, 5'd0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("reset_initial_release", 2'd0, 5'd0, 5'd0);

        // Vector table.
        for (int i = 0; i < C_NVEC; i++) begin
            press(tbl[i].which, tbl[i].hold);
            check($sformatf("vec%0d", i), tbl[i].exp_w, tbl[i].exp_fc, tbl[i].exp_fc2);
        end

        do_reset();

        // Wave presses with exact latency: update on the 12th edge after the fall.
        wave_exp[0] = 2'd1; wave_exp[1] = 2'd2; wave_exp[2] = 2'd3;
        wave_exp[3] = 2'd0; wave_exp[4] = 2'd1;
        wprev = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            key_wave_n = 1'b0;
            repeat (11) @(posedge sys_clk);
            #1 check($sformatf("wave%0d_before", i), wprev, 5'd0, 5'd0);
            @(posedge sys_clk);
            #1 check($sformatf("wave%0d_after", i), wave_exp[i], 5'd0, 5'd0);
            repeat (9) @(negedge sys_clk);
            key_wave_n = 1'b1;
            repeat (15) @(negedge sys_clk);
            wprev = wave_exp[i];
        end

        // Bounce: 3-cycle low/high chatter never registers, then a real hold.
        @(negedge sys_clk);
        for (int c = 0; c < 40; c++) begin
            key_up_n = (((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
            @(negedge sys_clk);
        end
        check("bounce_chatter", 2'd1, 5'd0, 5'd0);
        key_up_n = 1'b0;
        repeat (15) @(negedge sys_clk);
        key_up_n = 1'b1;
        repeat (16) @(negedge sys_clk);
        check("bounce_hold", 2'd1, 5'd1, 5'd0);
        press(K_UP, 8);
        check("short_hold", 2'd1, 5'd1, 5'd0);

        // Up saturation from fc=1.
        for (int i = 0; i < 35; i++) begin
            press(K_UP, 12);
            efc = (i + 2 > 31) ? 31 : i + 2;
            check($sformatf("up_sat%0d", i), 2'd1, 5'(efc), 5'd0);
        end

        // Down through zero into freq_counter2, saturating at 19.
        for (int j = 0; j < 55; j++) begin
            press(K_DN, 12);
            efc  = (31 - (j + 1) < 0) ? 0 : 31 - (j + 1);
            efc2 = (j + 1 <= 31) ? 0 : (((j + 1 - 31) > 19) ? 19 : j + 1 - 31);
            check($sformatf("dn_sat%0d", j), 2'd1, 5'(efc), 5'(efc2));
        end

        // Reset in the middle of a down press.
        @(negedge sys_clk);
        key_dn_n = 1'b0;
        repeat (8) @(negedge sys_clk);
        check("midpress_before_reset", 2'd1, 5'd0, 5'd19);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("midpress_in_reset", 2'd0, 5'd0, 5'd0);
        sys_rst_n = 1'b1;
        repeat (11) @(posedge sys_clk);
        #1 check("midpress_before_pulse", 2'd0, 5'd0, 5'd0);
        @(posedge sys_clk);
        #1 check("midpress_after_pulse", 2'd0, 5'd0, 5'd1);
        @(negedge sys_clk);
        key_dn_n = 1'b1;
        repeat (16) @(negedge sys_clk);
        check("midpress_settled", 2'd0, 5'd0, 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dds_key_ctrl
`default_nettype wire
